fetcher: RTL and testbench
==========================

// Module: fetcher
//
// PURPOSE
// - Instruction fetch stage of one GPU core; sits directly upstream of the decoder.
// - On the core's FETCH state, issues one read to program memory at the current PC.
// - Holds the returned 16-bit instruction stable for the decoder's DECODE state.
// - Reports progress to the core scheduler through fetcher_state.
//
// PARAMETERS
// - PROGRAM_MEM_ADDR_BITS  8   width of PC and program memory address
// - PROGRAM_MEM_DATA_BITS  16  instruction width; fixed at 16 for the current ISA
//
// PORTS
// - clk               in   1   core clock; all state updates on posedge
// - reset             in   1   synchronous, active-high
// - core_state        in   3   scheduler state; 3'b001 = FETCH, 3'b010 = DECODE
// - current_pc        in   A   PC to fetch (A = PROGRAM_MEM_ADDR_BITS)
// - mem_read_valid    out  1   read request to program memory controller
// - mem_read_address  out  A   request address; stable while mem_read_valid = 1
// - mem_read_ready    in   1   memory response strobe; data valid this cycle
// - mem_read_data     in   D   returned instruction word (D = PROGRAM_MEM_DATA_BITS)
// - fetcher_state     out  3   3'b000 IDLE, 3'b001 FETCHING, 3'b010 FETCHED
// - instruction       out  D   last captured instruction; feeds decoder
//
// BEHAVIOUR
// Reset (synchronous, active-high)
// - mem_read_valid = 0, mem_read_address = 0, fetcher_state = IDLE, instruction = 0.
// - Reset asserted mid-fetch drops mem_read_valid at that edge; no capture occurs.
//
// FSM (all outputs registered)
// - IDLE -> FETCHING: when core_state == FETCH.
//   Same edge sets mem_read_valid = 1 and mem_read_address = current_pc.
// - FETCHING: holds valid and address unchanged until mem_read_ready = 1 is sampled.
//   On that edge: instruction <= mem_read_data, mem_read_valid <= 0, -> FETCHED.
// - FETCHED -> IDLE: when core_state == DECODE. instruction is held, never cleared.
// - Other core_state values: no transition in any state.
//
// Handshake rules
// - Request once issued always completes, even if core_state leaves FETCH.
// - mem_read_ready is ignored outside FETCHING.
// - current_pc changes after issue do not affect the in-flight address.
//
// Latency
// - FETCH sampled at edge N -> mem_read_valid = 1 after edge N.
// - Ready sampled at edge M (M > N) -> FETCHED and new instruction after edge M.
// - Minimum 2 edges from FETCH to FETCHED; zero-wait memory gives exactly 2.
//
// Boundary cases
// - current_pc = 2^A-1 is a legal address; no wrap or increment happens here.
// - Back-to-back fetches need a DECODE-driven return to IDLE between them.
//
// CONFIGURATION
// - Macro FETCH_CACHE_EN adds a one-entry instruction cache.
// - State added: tag register (width A) and valid bit; both cleared by reset.
// - Each memory capture writes tag = issued address and sets valid = 1.
// - IDLE with core_state == FETCH, valid = 1, current_pc == tag:
//   -> FETCHED directly after 1 edge; mem_read_valid stays 0; instruction unchanged.
// - Miss: normal FETCHING path.
// - Macro undefined: no tag logic; every fetch goes to memory.
//
// TESTING
// - Reset with mem_read_ready = 1 toggling -> valid = 0, addr = 0, state = 000, instr = 16'h0000.
// - PC = 8'h05, FETCH, ready on first valid cycle with data 16'h3123
//   -> 1 request at addr 05, FETCHED 2 edges after FETCH, instr = 16'h3123.
// - PC = 8'h10, ready delayed 5 cycles, PC changed to 8'h11 mid-wait
//   -> addr stays 10 and valid stays 1 until ready, then capture.
// - Reset asserted during FETCHING
//   -> valid = 0 and state = IDLE next edge; later ready pulse leaves instr unchanged.
// - FETCHED with core_state = DECODE -> IDLE, instr held;
//   next FETCH at PC = 8'hFF -> request addr FF.
// - FETCH_CACHE_EN: fetch PC = 8'h07 twice (data 16'h9A42)
//   -> second fetch gives no mem_read_valid, FETCHED after 1 edge, instr = 16'h9A42.

Source files
------------

// File: rtl/fetcher.sv
// ============================================================================
// Module   : fetcher
// Purpose  : Instruction fetch stage; one program-memory read per FETCH,
//            instruction held for DECODE. Optional one-entry instruction
//            cache enabled by macro FETCH_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam logic [2:0] c_core_fetch  = 3'b001;
  localparam logic [2:0] c_core_decode = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t                             r_state, w_state_next;
  logic                               r_valid, w_valid_next;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_addr, w_addr_next;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr, w_instr_next;
  logic                               w_capture;
  logic                               w_hit;

`ifdef FETCH_CACHE_EN
  logic                               r_tag_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_tag;

  // The tag records the address actually issued, not the live PC.
  assign w_hit = r_tag_valid && (current_pc == r_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
    end else if (w_capture) begin
      r_tag_valid <= 1'b1;
      r_tag       <= r_addr;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_addr_next  = r_addr;
    w_instr_next = r_instr;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_state == c_core_fetch) begin
          if (w_hit) begin
            w_state_next = S_FETCHED;
          end else begin
            w_state_next = S_FETCHING;
            w_valid_next = 1'b1;
            w_addr_next  = current_pc;
          end
        end
      end
      S_FETCHING: begin
        // Once issued, the request completes regardless of core_state.
        if (mem_read_ready) begin
          w_capture    = 1'b1;
          w_instr_next = mem_read_data;
          w_valid_next = 1'b0;
          w_state_next = S_FETCHED;
        end
      end
      S_FETCHED: begin
        if (core_state == c_core_decode) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      r_addr  <= w_addr_next;
      r_instr <= w_instr_next;
    end
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_fetcher.sv
// ============================================================================
// Module   : tb_fetcher
// Purpose  : Directed self-checking bench for the fetcher stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetcher;

  localparam logic [2:0] c_idle_cs   = 3'b000;
  localparam logic [2:0] c_fetch_cs  = 3'b001;
  localparam logic [2:0] c_decode_cs = 3'b010;

  logic        clk;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int n_checks;
  int n_pass;

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .core_state      (core_state),
    .current_pc      (current_pc),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instruction     (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs re-driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    reset          = 1'b1;
    core_state     = c_idle_cs;
    current_pc     = 8'h00;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hBEEF;

    // Reset with ready toggling
    for (int i = 0; i < 4; i++) begin
      mem_read_ready = ~mem_read_ready;
      core_state     = (i == 1) ? c_fetch_cs : c_idle_cs;
      tick();
    end
    check("rst_valid", 32'(mem_read_valid), 32'd0);
    check("rst_addr",  32'(mem_read_address), 32'h00);
    check("rst_state", 32'(fetcher_state), 32'd0);
    check("rst_instr", 32'(instruction), 32'h0000);
    reset          = 1'b0;
    mem_read_ready = 1'b0;
    core_state     = c_idle_cs;
    tick();
    check("idle_state", 32'(fetcher_state), 32'd0);

    // Zero-wait fetch at 0x05
    current_pc    = 8'h05;
    core_state    = c_fetch_cs;
    mem_read_data = 16'h3123;
    tick();
    check("f05_valid", 32'(mem_read_valid), 32'd1);
    check("f05_addr",  32'(mem_read_address), 32'h05);
    check("f05_state", 32'(fetcher_state), 32'd1);
    mem_read_ready = 1'b1;
    core_state     = c_idle_cs;
    tick();
    check("f05_done_state", 32'(fetcher_state), 32'd2);
    check("f05_instr",      32'(instruction), 32'h3123);
    check("f05_valid_low",  32'(mem_read_valid), 32'd0);
    mem_read_ready = 1'b0;
    core_state     = c_decode_cs;
    tick();
    check("dec_state", 32'(fetcher_state), 32'd0);
    check("dec_instr", 32'(instruction), 32'h3123);

    // Delayed ready with PC change mid-wait
    current_pc = 8'h10;
    core_state = c_fetch_cs;
    tick();
    check("f10_addr", 32'(mem_read_address), 32'h10);
    current_pc = 8'h11;
    core_state = c_idle_cs;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("f10_wait_valid", 32'(mem_read_valid), 32'd1);
      check("f10_wait_addr",  32'(mem_read_address), 32'h10);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h4567;
    tick();
    check("f10_state", 32'(fetcher_state), 32'd2);
    check("f10_instr", 32'(instruction), 32'h4567);
    check("f10_valid", 32'(mem_read_valid), 32'd0);
    mem_read_ready = 1'b0;
    core_state     = c_decode_cs;
    tick();

    // Ready in IDLE is ignored
    core_state     = c_idle_cs;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    tick();
    check("idle_rdy_instr", 32'(instruction), 32'h4567);
    check("idle_rdy_state", 32'(fetcher_state), 32'd0);
    mem_read_ready = 1'b0;

    // Reset during FETCHING
    current_pc = 8'h20;
    core_state = c_fetch_cs;
    tick();
    check("f20_valid", 32'(mem_read_valid), 32'd1);
    core_state = c_idle_cs;
    reset      = 1'b1;
    tick();
    check("midrst_valid", 32'(mem_read_valid), 32'd0);
    check("midrst_state", 32'(fetcher_state), 32'd0);
    reset          = 1'b0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hAAAA;
    tick();
    check("midrst_instr", 32'(instruction), 32'h0000);
    check("midrst_state2", 32'(fetcher_state), 32'd0);
    mem_read_ready = 1'b0;

    // FETCHED holds on non-DECODE states, then PC 0xFF fetch
    current_pc = 8'h30;
    core_state = c_fetch_cs;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1111;
    tick();
    mem_read_ready = 1'b0;
    core_state     = 3'b100;
    tick();
    check("hold_state", 32'(fetcher_state), 32'd2);
    core_state = c_decode_cs;
    tick();
    check("f30_idle", 32'(fetcher_state), 32'd0);
    check("f30_instr", 32'(instruction), 32'h1111);
    current_pc = 8'hFF;
    core_state = c_fetch_cs;
    tick();
    check("fff_valid", 32'(mem_read_valid), 32'd1);
    check("fff_addr",  32'(mem_read_address), 32'hFF);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h2222;
    tick();
    check("fff_instr", 32'(instruction), 32'h2222);
    mem_read_ready = 1'b0;
    core_state     = c_decode_cs;
    tick();

    // Repeat fetch at 0x07
    current_pc = 8'h07;
    core_state = c_fetch_cs;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h9A42;
    tick();
    check("f07_instr", 32'(instruction), 32'h9A42);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0BAD;
    core_state     = c_decode_cs;
    tick();
    core_state = c_fetch_cs;
    tick();
`ifdef FETCH_CACHE_EN
    check("hit_valid", 32'(mem_read_valid), 32'd0);
    check("hit_state", 32'(fetcher_state), 32'd2);
    check("hit_instr", 32'(instruction), 32'h9A42);
`else
    check("refetch_valid", 32'(mem_read_valid), 32'd1);
    check("refetch_state", 32'(fetcher_state), 32'd1);
    check("refetch_addr",  32'(mem_read_address), 32'h07);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h9A42;
    tick();
    check("refetch_instr", 32'(instruction), 32'h9A42);
    mem_read_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
